// File: rtl/conv3d_layer_sequencer_pkg.sv
// Shared definitions for the conv3d layer sequencer: FSM encoding and
// the input-buffer read latency.
package conv3d_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4
  } seq_state_t;

  // Cycles between rd_en and valid data at the datapath input.
  localparam int unsigned RD_LATENCY = 1;

endpackage

// File: rtl/conv3d_layer_sequencer.sv
// conv3d_layer_sequencer: runs NUM_PASSES passes of an 8-channel conv
// datapath over one IMG_WIDTH x IMG_HEIGHT feature map. Each pass streams
// every pixel out of the input buffer, then waits for the datapath to
// flush its last pixel before moving to the next weight set.
//
// Optional drain watchdog: define CONV_SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | reading pixels 0..N-1 from the input buffer
// DRAIN  | all reads issued, collecting remaining outputs
// NEXT   | one cycle: advance to next pass or finish
// FINISH | one cycle: done pulse
module conv3d_layer_sequencer
  import conv3d_layer_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int IMG_WIDTH      = 56,
  parameter int IMG_HEIGHT     = 56,
  parameter int NUM_PASSES     = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  conv_valid_in,
  input  logic                  conv_valid_out,
  input  logic                  conv_done,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            pass_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int N = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX  = ADDR_WIDTH'(N - 1);
  localparam logic [7:0]            LAST_PASS = 8'(NUM_PASSES - 1);

  // Reject parameter sets the address map or pass counter cannot hold.
  if (DATA_WIDTH < 1 || NUM_PASSES < 1 || NUM_PASSES > 256 || TIMEOUT_CYCLES < 1 ||
      (64'(1) << ADDR_WIDTH) < 64'(N) * 64'(NUM_PASSES)) begin : g_param_check
    $error("conv3d_layer_sequencer: invalid parameter set");
  end

  seq_state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] out_cnt;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic run_start;
  logic frame_end;
  logic wd_expire;

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (state == ST_DRAIN) && !conv_valid_out &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts idle DRAIN cycles, restarts on every output pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      wd_cnt <= '0;
    else if (state != ST_DRAIN || conv_valid_out)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next state and per-state strobes; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    run_start = 1'b0;
    frame_end = 1'b0;
    case (state)
      ST_IDLE: begin
        run_start = start && !abort;
        if (run_start)
          state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        rd_en = 1'b1;
        wr_en = conv_valid_out;
        if (rd_addr == LAST_PIX)
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        wr_en     = conv_valid_out;
        frame_end = conv_valid_out && conv_done;
        if (frame_end)
          state_nxt = ST_NEXT;
        else if (wd_expire)
          state_nxt = ST_IDLE;
      end
      ST_NEXT: begin
        state_nxt = (pass_idx < LAST_PASS) ? ST_ISSUE : ST_FINISH;
      end
      ST_FINISH: begin
        done      = !abort;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE)
      state_nxt = ST_IDLE;
  end

  // Read/write counters, pass index, sticky error and read-latency pipe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_addr  <= '0;
      out_cnt  <= '0;
      pass_idx <= '0;
      error    <= 1'b0;
      rd_pipe  <= '0;
    end else begin
      rd_pipe <= RD_LATENCY'({rd_pipe, rd_en});
      if (run_start) begin
        rd_addr  <= '0;
        out_cnt  <= '0;
        pass_idx <= '0;
        error    <= 1'b0;
      end else begin
        if (rd_en && rd_addr != LAST_PIX)
          rd_addr <= rd_addr + 1'b1;
        if (wr_en)
          out_cnt <= (out_cnt == LAST_PIX) ? '0 : out_cnt + 1'b1;
        if (state == ST_NEXT && state_nxt == ST_ISSUE) begin
          pass_idx <= pass_idx + 1'b1;
          rd_addr  <= '0;
        end
        // A short frame still advances the pass, but is remembered.
        if (((frame_end && out_cnt != LAST_PIX) || wd_expire) && !abort)
          error <= 1'b1;
      end
    end
  end

  assign conv_valid_in = rd_pipe[RD_LATENCY-1];
  assign busy          = (state != ST_IDLE);
  assign wr_addr       = ADDR_WIDTH'(N * int'(pass_idx)) + out_cnt;

endmodule

// File: doc/conv3d_layer_sequencer.md
CONV3D_LAYER_SEQUENCER -- requirements
Module: conv3d_layer_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, 32, pixel word width; width only, not used internally.
REQ-002 Parameter IMG_WIDTH, 56, feature-map width in pixels.
REQ-003 Parameter IMG_HEIGHT, 56, feature-map height in pixels; N = IMG_WIDTH*IMG_HEIGHT.
REQ-004 Parameter NUM_PASSES, 4, output-filter passes per layer run (1..256).
REQ-005 Parameter ADDR_WIDTH, 16, buffer address width; must satisfy 2^ADDR_WIDTH >= N*NUM_PASSES.
REQ-006 Parameter TIMEOUT_CYCLES, 4096, drain watchdog limit.
REQ-007 clk  in  1  clock, rising edge.
REQ-008 resetn  in  1  reset, asynchronous, active-low.
REQ-009 start  in  1  single-cycle request to run a layer.
REQ-010 abort  in  1  synchronous cancel of the current run.
REQ-011 rd_en  out  1  input-buffer read strobe; the buffer is 8 channels wide.
REQ-012 rd_addr  out  ADDR_WIDTH  input-buffer pixel address.
REQ-013 conv_valid_in  out  1  drives data_valid_in of the 8-channel convolution datapath.
REQ-014 conv_valid_out  in  1  valid_out_pixel from the datapath.
REQ-015 conv_done  in  1  done from the datapath; marks the last pixel of a frame.
REQ-016 wr_en  out  1  output-buffer write strobe.
REQ-017 wr_addr  out  ADDR_WIDTH  output-buffer address.
REQ-018 pass_idx  out  8  current pass; selects the weight set.
REQ-019 busy  out  1  high whenever the state is not IDLE.
REQ-020 done  out  1  one-cycle pulse when all passes complete.
REQ-021 error  out  1  sticky fault flag.

Function
REQ-022 FSM states: IDLE, ISSUE, DRAIN, NEXT, FINISH.
REQ-023 IDLE->ISSUE on start; clear pass_idx, rd_addr, out_cnt and error.
REQ-024 start is ignored while busy.
REQ-025 ISSUE: rd_en=1 every cycle, with rd_addr stepping 0..N-1.
REQ-026 ISSUE->DRAIN in the cycle after rd_addr=N-1 is issued.
REQ-027 conv_valid_in = rd_en delayed one cycle (one-cycle buffer read latency); it stays aligned across all state changes.
REQ-028 wr_en = conv_valid_out while in ISSUE or DRAIN; otherwise wr_en=0.
REQ-029 wr_addr = pass_idx*N + out_cnt, combinational.
REQ-030 out_cnt increments on each conv_valid_out and wraps to 0 after N-1.
REQ-031 Output pixels may arrive during ISSUE; they are written normally.
REQ-032 DRAIN->NEXT when conv_valid_out and conv_done are both high.
REQ-033 conv_done with out_cnt != N-1 sets error; the transition still occurs.
REQ-034 NEXT lasts one cycle: if pass_idx<NUM_PASSES-1, increment pass_idx and reset rd_addr, then go to ISSUE; else go to FINISH.
REQ-035 FINISH lasts one cycle: done=1, then go to IDLE.
REQ-036 abort in any non-IDLE state:
- next state is IDLE, rd_en=0 next cycle, done is not asserted;
- an in-flight conv_valid_in still drains out after the one-cycle read latency.
REQ-037 abort has priority over every other transition in the same cycle, including the one from FINISH.
REQ-038 start and abort together in IDLE: start is ignored.

Reset
REQ-039 On resetn low: state=IDLE and every output and counter is 0.
REQ-040 resetn low mid-run stops the run immediately.
REQ-041 Datapath reset is external and shares resetn.

Configuration
REQ-042 Macro CONV_SEQ_TIMEOUT_EN defined:
- a watchdog counts cycles in DRAIN and clears on each conv_valid_out;
- on reaching TIMEOUT_CYCLES it sets error and goes to IDLE, with no done pulse.
REQ-043 Macro CONV_SEQ_TIMEOUT_EN undefined: no watchdog logic, DRAIN waits indefinitely, error is set only per REQ-033.

Structure
REQ-044 Shared package holds:
- the FSM state encoding, 3 bits: IDLE=0, ISSUE=1, DRAIN=2, NEXT=3, FINISH=4;
- the read-latency constant (1).
REQ-045 Single module; no sub-modules.
REQ-046 The watchdog is an inline counter, not a sub-module.

Verification
REQ-047 IMG 4x4, NUM_PASSES=2, datapath model with latency 20 and start pulse:
- rd_en high for exactly 16 cycles per pass;
- wr_addr sequence 0..31;
- done pulses once; busy falls the cycle after done.
REQ-048 start pulsed again while busy -> no restart; rd_addr sequence unchanged.
REQ-049 abort in pass 0 at rd_addr=7 -> next cycle state=IDLE, rd_en=0; conv_valid_in high one more cycle; done never asserted.
REQ-050 conv_done asserted at the 10th output (out_cnt=9) -> error=1; the sequencer continues to NEXT; error clears on the next start.
REQ-051 With CONV_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=64, model stops after 12 outputs -> error set 64 cycles later; IDLE, no done.
REQ-052 resetn asserted mid-DRAIN -> all outputs 0 asynchronously; a fresh start runs the full sequence cleanly.
